// File: rtl/ifid_fetch_ctrl.sv
// ifid_fetch_ctrl: fetch-stage sequencing for the 5-stage pipeline.
// Produces PC write enable, IF/ID capture/flush and the ID/EX bubble from
// I-cache status, load-use hazards and taken branches. It also runs the
// refill request/ack handshake with a timeout into a sticky error state.
module ifid_fetch_ctrl #(
  parameter int REG_W          = 5,
  parameter int REFILL_TIMEOUT = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             icache_hit,
  input  logic             refill_ack,
  output logic             refill_req,
  input  logic             branch_taken,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             refill_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = $clog2(REFILL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               lu;

  // Load-use hazard against the load in EX; $0 never creates a dependency.
  always_comb begin
    lu = idex_memread && (idex_rt != '0) &&
         ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

  // Mealy pipeline controls, all held at 0 while reset is asserted.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rstn) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
          end else if (lu) begin
            idex_bubble = 1'b1;
          end else if (!icache_hit) begin
            ifid_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        MISS:    ifid_flush = 1'b1;
        ERROR:   ifid_flush = 1'b1;
        default: ifid_flush = 1'b0;
      endcase
    end
  end

  // State-derived outputs; the async reset moves state to RUN immediately.
  always_comb begin
    refill_req   = (state_q == MISS);
    refill_error = err_q;
    stall_count  = cnt_q;
  end

  // State, refill timer, sticky error flag and saturating stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      tmr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q != ERROR) && !pc_write && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        RUN: begin
          tmr_q <= '0;
          if (!branch_taken && !lu && !icache_hit) begin
            state_q <= MISS;
            tmr_q   <= TMR_W'(1);
          end
        end
        MISS: begin
          if (refill_ack) begin
            state_q <= RUN;
            tmr_q   <= '0;
          end else if (tmr_q == TMR_W'(REFILL_TIMEOUT)) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ERROR:   state_q <= ERROR;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_fetch_ctrl.sv
// Self-checking bench for ifid_fetch_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_ifid_fetch_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 64;
  localparam int CW      = 6;
  localparam int CMAX    = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             icache_hit = 1'b1;
  logic             refill_ack = 1'b0;
  logic             branch_taken = 1'b0;
  logic             idex_memread = 1'b0;
  logic [REG_W-1:0] idex_rt = '0;
  logic [REG_W-1:0] ifid_rs = '0;
  logic [REG_W-1:0] ifid_rt = '0;
  logic             refill_req, pc_write, ifid_write, ifid_flush, idex_bubble, refill_error;
  logic [CW-1:0]    stall_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0=running, 1=waiting for refill, 2=dead after timeout.
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;
  bit m_err   = 0;

  ifid_fetch_ctrl #(.REG_W(REG_W), .REFILL_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .icache_hit(icache_hit), .refill_ack(refill_ack),
    .refill_req(refill_req), .branch_taken(branch_taken), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .refill_error(refill_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit hit, input bit ack, input bit br, input bit mr,
                        input int rt, input int rs, input int irt);
    icache_hit   = hit;
    refill_ack   = ack;
    branch_taken = br;
    idex_memread = mr;
    idex_rt      = REG_W'(rt);
    ifid_rs      = REG_W'(rs);
    ifid_rt      = REG_W'(irt);
  endtask

  // Check the current cycle against the model, then advance both one edge.
  task automatic cycle();
    bit hz, e_pc, e_ifw, e_fl, e_bub;
    #2;
    hz = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0;
    if (m_mode == 0) begin
      if (branch_taken)     begin e_pc = 1; e_fl = 1; end
      else if (hz)          e_bub = 1;
      else if (!icache_hit) e_fl = 1;
      else                  begin e_pc = 1; e_ifw = 1; end
    end else begin
      e_fl = 1;
    end
    check("pc_write", pc_write, e_pc);
    check("ifid_write", ifid_write, e_ifw);
    check("ifid_flush", ifid_flush, e_fl);
    check("idex_bubble", idex_bubble, e_bub);
    check("refill_req", refill_req, m_mode == 1);
    check("refill_error", refill_error, m_err);
    check("stall_count", stall_count, m_stall);
    if (m_mode != 2 && !e_pc) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    if (m_mode == 0) begin
      if (!branch_taken && !hz && !icache_hit) begin m_mode = 1; m_wait = 1; end
    end else if (m_mode == 1) begin
      if (refill_ack) m_mode = 0;
      else if (m_wait == TIMEOUT) begin m_mode = 2; m_err = 1; end
      else m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock.
  task automatic async_reset();
    #1;
    rstn = 1'b0;
    #1;
    check("rst_refill_req", refill_req, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_ifid_write", ifid_write, 0);
    check("rst_ifid_flush", ifid_flush, 0);
    check("rst_idex_bubble", idex_bubble, 0);
    check("rst_refill_error", refill_error, 0);
    check("rst_stall_count", stall_count, 0);
    m_mode = 0; m_wait = 0; m_stall = 0; m_err = 0;
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rst_hold_pc_write", pc_write, 0);
    check("rst_hold_ifid_write", ifid_write, 0);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    async_reset();

    // Hit after reset: normal advance.
    set_in(1, 0, 0, 0, 0, 0, 0);
    #2;
    check("post_rst_pc_write", pc_write, 1);
    check("post_rst_ifid_write", ifid_write, 1);
    cycle();

    // Miss, ack in the third MISS cycle.
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();
    cycle();
    set_in(1, 1, 0, 0, 0, 0, 0); cycle();
    check("miss3_stall_count", stall_count, 4);
    check("miss3_back_req", refill_req, 0);
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();

    // Load-use masks a miss for one cycle, then the miss is taken.
    set_in(0, 0, 0, 1, 8, 8, 3);
    #2;
    check("lu_bubble", idex_bubble, 1);
    check("lu_pc_write", pc_write, 0);
    cycle();
    check("lu_no_req", refill_req, 0);
    set_in(0, 0, 0, 0, 8, 8, 3); cycle();
    check("lu_then_miss_req", refill_req, 1);
    set_in(1, 1, 0, 0, 0, 0, 0); cycle();

    // Register $0 never stalls.
    set_in(1, 0, 0, 1, 0, 0, 0);
    #2;
    check("r0_pc_write", pc_write, 1);
    check("r0_bubble", idex_bubble, 0);
    cycle();

    // Branch beats load-use and miss.
    set_in(0, 0, 1, 1, 5, 0, 5);
    #2;
    check("br_pc_write", pc_write, 1);
    check("br_flush", ifid_flush, 1);
    check("br_bubble", idex_bubble, 0);
    cycle();
    check("br_no_miss", refill_req, 0);

    // Reset in the middle of MISS.
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();
    check("mid_miss_req", refill_req, 1);
    async_reset();
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();

    // Timeout into ERROR; acks afterwards are ignored.
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) cycle();
    check("to_error", refill_error, 1);
    check("to_req", refill_req, 0);
    check("to_stall_sat", stall_count, CMAX);
    set_in(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("to_sticky", refill_error, 1);
    async_reset();

    // Ack on the final allowed MISS cycle still recovers.
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle();
    set_in(1, 1, 0, 0, 0, 0, 0); cycle();
    check("last_ack_no_error", refill_error, 0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    #2;
    check("last_ack_pc_write", pc_write, 1);
    cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) async_reset();
      set_in($urandom_range(9, 0) < 7, $urandom_range(7, 0) == 0,
             $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1,
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifid_fetch_ctrl.md
# ifid_fetch_ctrl

Fetch-stage sequencing controller for the 5-stage MIPS pipeline. It generates the PC write enable and the IF/ID pipeline register's capture enable (`hit`) and flush, and the ID/EX bubble. It does this from instruction-cache hit/miss status, load-use hazards and taken branches. On a cache miss it runs a refill request/acknowledge handshake with a timeout.

## Interface
Parameters:
- `REG_W`, 5, register-specifier width
- `REFILL_TIMEOUT`, 64, max cycles in MISS without `refill_ack` before ERROR (>=2)
- `CNT_W`, 16, width of `stall_count`

Ports:
- `clk`  in  1  pipeline clock; state updates on posedge
- `rstn`  in  1  asynchronous, active-low reset
- `icache_hit`  in  1  current-PC fetch hit
- `refill_ack`  in  1  one-cycle pulse: refill complete
- `refill_req`  out  1  refill request, level, held until ack/timeout
- `branch_taken`  in  1  branch in ID resolved taken
- `idex_memread`  in  1  instruction in EX is a load
- `idex_rt`  in  REG_W  load destination in EX
- `ifid_rs`  in  REG_W  rs of instruction in ID
- `ifid_rt`  in  REG_W  rt of instruction in ID
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID capture enable (drives IF/ID `hit`)
- `ifid_flush`  out  1  IF/ID loads all-zero (NOP) instead of fetch
- `idex_bubble`  out  1  ID/EX loads control-zero bubble
- `refill_error`  out  1  sticky: refill timed out
- `stall_count`  out  CNT_W  saturating count of fetch-stall cycles

## Operation
- States: RUN, MISS, ERROR. Reset state RUN. Timeout counter `tmr` is cleared in RUN.
- Load-use `lu` = `idex_memread` & (`idex_rt` != 0) & (`idex_rt`==`ifid_rs` | `idex_rt`==`ifid_rt`).
- RUN: evaluate in priority order:
  1. `branch_taken`: `pc_write`=1, `ifid_write`=0, `ifid_flush`=1. The wrong-path fetch is discarded, so a miss is ignored. Stay in RUN.
  2. `lu`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. A miss is ignored this cycle and re-evaluated next. Stay in RUN.
  3. `!icache_hit`: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1. Go to MISS with `tmr`=1.
  4. Otherwise: `pc_write`=1, `ifid_write`=1.
- MISS:
  - Outputs: `refill_req`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=1 (ID holds NOP, downstream drains).
  - `branch_taken` and `lu` are ignored.
  - `refill_ack` goes to RUN (the PC refetches and hits next cycle).
  - Else if `tmr`==`REFILL_TIMEOUT`, go to ERROR. Else `tmr`++.
  - An ack on the timeout cycle wins: go to RUN.
- ERROR:
  - Outputs: `refill_req`=0, `refill_error`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=1.
  - Left only by reset.
- `refill_ack` outside MISS is ignored.
- `stall_count` increments on every cycle with `pc_write`=0 in RUN or MISS, saturates at 2^CNT_W-1, and does not count in ERROR.
- Outputs not listed for a state/case are 0.

## Timing
- State, `tmr`, `stall_count` and `refill_error` are registered on posedge `clk`.
- `pc_write`, `ifid_write`, `ifid_flush` and `idex_bubble` are combinational (Mealy) from state and inputs. They are valid before the IF/ID register's negedge capture in the same cycle.
- `refill_req` is a function of state only. It rises the first posedge after the miss cycle.
- Reset (`rstn` low, asynchronous, any state including mid-MISS): state RUN, `tmr`=0, `stall_count`=0, `refill_error`=0. All outputs are forced to 0 while `rstn` is low, including `refill_req`, which drops immediately.
- Miss latency: miss cycle + N MISS cycles (ack in the Nth) → RUN. The fetch redoes the cycle after the ack. Stall cycles counted = N+1.
- Load-use stall is exactly one cycle when the EX load advances normally.

## Test plan
- Reset mid-MISS (refill_req=1) → all outputs 0 immediately. After release: RUN, stall_count=0, and hit gives pc_write=ifid_write=1.
- Miss, ack after 3 MISS cycles → refill_req high 3 cycles; ifid_flush=1 for 4 cycles; back in RUN; stall_count=4.
- idex_memread=1, idex_rt=8, ifid_rs=8, icache_hit=0 → 1 cycle of pc_write=0/ifid_write=0/idex_bubble=1, no refill_req. Next cycle (lu clear) enters MISS.
- idex_rt=0 with match, memread=1 → no stall (register $0 excluded).
- branch_taken=1 with icache_hit=0 and lu=1 → pc_write=1, ifid_flush=1, idex_bubble=0, no MISS entry.
- No ack for REFILL_TIMEOUT=64 cycles → ERROR: refill_req=0, refill_error=1, pc_write=0 persistent, stall_count frozen. An ack on cycle 64 instead returns to RUN with no error.
